// File: rtl/data_bus_ctrl_pkg.sv
// Shared defines for the data/instruction bus controllers: FSM encodings,
// pipeline stall-vector layout and legacy enable/zero constants.
package data_bus_ctrl_pkg;

    localparam logic [1:0] DBUS_IDLE = 2'd0;
    localparam logic [1:0] DBUS_BUSY = 2'd1;
    localparam logic [1:0] DBUS_HOLD = 2'd2;

    localparam int unsigned MEM_STALL_BIT = 4;

    localparam logic        WriteEnable = 1'b1;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

endpackage

// File: rtl/data_bus_ctrl.sv
// Data-side Wishbone-classic master: turns a MEM-stage request into one bus
// cycle, stalls the pipeline until ack and keeps read data while stalled.
module data_bus_ctrl
    import data_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_ce_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_W-1:0]     cpu_addr_i,
    input  logic [DATA_W/8-1:0]   cpu_sel_i,
    input  logic [DATA_W-1:0]     cpu_data_i,
    output logic [DATA_W-1:0]     cpu_data_o,
    output logic                  stall_req_o,
    input  logic [5:0]            stall_i,
    input  logic                  flush_i,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_W-1:0]     wb_adr_o,
    output logic [DATA_W/8-1:0]   wb_sel_o,
    output logic [DATA_W-1:0]     wb_dat_o,
    input  logic [DATA_W-1:0]     wb_dat_i,
    input  logic                  wb_ack_i
);

    logic [1:0]        state;
    logic [DATA_W-1:0] rd_buf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DBUS_IDLE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_sel_o <= '0;
            wb_dat_o <= '0;
            rd_buf   <= '0;
        end else begin
            case (state)
                DBUS_IDLE: begin
                    if (cpu_ce_i == ChipEnable && !flush_i) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= (cpu_we_i == WriteEnable);
                        wb_adr_o <= cpu_addr_i;
                        wb_sel_o <= cpu_sel_i;
                        wb_dat_o <= cpu_data_i;
                        state    <= DBUS_BUSY;
                    end
                end
                DBUS_BUSY: begin
                    // Flush wins over a coincident ack: the access is discarded.
                    if (flush_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        state    <= DBUS_IDLE;
                    end else if (wb_ack_i) begin
                        rd_buf   <= wb_dat_i;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        state    <= stall_i[MEM_STALL_BIT] ? DBUS_HOLD : DBUS_IDLE;
                    end
                end
                DBUS_HOLD: begin
                    if (!stall_i[MEM_STALL_BIT] || flush_i) begin
                        state <= DBUS_IDLE;
                    end
                end
                default: state <= DBUS_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_req_o = 1'b0;
        cpu_data_o  = '0;
        if (!rst) begin
            case (state)
                DBUS_IDLE: stall_req_o = (cpu_ce_i == ChipEnable) && !flush_i;
                DBUS_BUSY: begin
                    if (!flush_i) begin
                        if (wb_ack_i) begin
                            cpu_data_o = wb_we_o ? '0 : wb_dat_i;
                        end else begin
                            stall_req_o = 1'b1;
                        end
                    end
                end
                DBUS_HOLD: cpu_data_o = rd_buf;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Self-checking bench for data_bus_ctrl: vector table with a Wishbone slave
// driven inline, scoreboard of expected bus/return values, plus corner cases.
module tb_data_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce_i, cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
    logic [3:0]  cpu_sel_i;
    logic        stall_req_o;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;

    data_bus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .stall_req_o(stall_req_o), .stall_i(stall_i), .flush_i(flush_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned waits;
        int unsigned hold;
        logic [31:0] exp_cpu;
    } vec_t;

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        we;
        logic [31:0] cpu;
    } exp_t;

    exp_t sb[$];
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned bus_cycles = 0;
    logic        prev_cyc = 1'b0;

    // Counts rising edges of cyc so overlapping or extra bus cycles show up.
    always @(posedge clk) begin
        prev_cyc <= wb_cyc_o;
        if (wb_cyc_o && !prev_cyc) bus_cycles <= bus_cycles + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        exp_t e;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = v.we;
        cpu_addr_i = v.addr;
        cpu_sel_i  = v.sel;
        cpu_data_i = v.wdata;
        flush_i    = 1'b0;
        wb_ack_i   = 1'b0;
        stall_i    = 6'b0;
        sb.push_back('{adr: v.addr, sel: v.sel, dat: v.wdata, we: v.we, cpu: v.exp_cpu});
        @(negedge clk);
        check("gap_cyc_low", {63'b0, wb_cyc_o}, 64'd0);
        check("req_stall", {63'b0, stall_req_o}, 64'd1);
        next_cycle();
        // Scramble the request inputs: the latched bus cycle must not follow them.
        cpu_ce_i   = 1'b0;
        cpu_we_i   = ~v.we;
        cpu_addr_i = ~v.addr;
        cpu_sel_i  = ~v.sel;
        cpu_data_i = $urandom;
        for (int unsigned w = 0; w <= v.waits; w++) begin
            if (w == v.waits) begin
                wb_ack_i   = 1'b1;
                wb_dat_i   = v.rdata;
                stall_i[4] = (v.hold != 0);
            end else begin
                wb_dat_i = $urandom;
            end
            @(negedge clk);
            check("busy_cyc", {62'b0, wb_cyc_o, wb_stb_o}, 64'd3);
            check("busy_stall", {63'b0, stall_req_o}, {63'b0, (w != v.waits)});
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                check("wb_adr", {32'b0, wb_adr_o}, {32'b0, sb[0].adr});
                check("wb_sel", {60'b0, wb_sel_o}, {60'b0, sb[0].sel});
                check("wb_dat", {32'b0, wb_dat_o}, {32'b0, sb[0].dat});
                check("wb_we", {63'b0, wb_we_o}, {63'b0, sb[0].we});
                if (w == v.waits) begin
                    e = sb.pop_front();
                    check("ack_cpu_data", {32'b0, cpu_data_o}, {32'b0, e.cpu});
                end else begin
                    check("wait_cpu_data", {32'b0, cpu_data_o}, 64'd0);
                end
            end
            next_cycle();
            wb_ack_i = 1'b0;
            wb_dat_i = $urandom;
        end
        if (v.hold != 0) begin
            // The stalled MEM instruction keeps presenting its request.
            cpu_ce_i   = 1'b1;
            cpu_we_i   = v.we;
            cpu_addr_i = v.addr;
            for (int unsigned h = 0; h < v.hold; h++) begin
                @(negedge clk);
                check("hold_data", {32'b0, cpu_data_o}, {32'b0, v.rdata});
                check("hold_cyc", {63'b0, wb_cyc_o}, 64'd0);
                check("hold_stall", {63'b0, stall_req_o}, 64'd0);
                next_cycle();
                wb_ack_i = 1'b1;
            end
            wb_ack_i   = 1'b0;
            stall_i[4] = 1'b0;
            @(negedge clk);
            check("hold_exit_data", {32'b0, cpu_data_o}, {32'b0, v.rdata});
            check("hold_exit_stall", {63'b0, stall_req_o}, 64'd0);
            next_cycle();
            cpu_ce_i = 1'b0;
        end
    endtask

    vec_t vecs[6];
    vec_t tv;
    int unsigned cyc_before;

    initial begin
        vecs[0] = '{we: 1'b0, addr: 32'h8000_0010, sel: 4'b1111, wdata: 32'h0, rdata: 32'hDEAD_BEEF, waits: 0, hold: 0, exp_cpu: 32'hDEAD_BEEF};
        vecs[1] = '{we: 1'b1, addr: 32'h0000_1004, sel: 4'b0100, wdata: 32'h5A5A_5A5A, rdata: 32'h1111_2222, waits: 3, hold: 0, exp_cpu: 32'h0};
        vecs[2] = '{we: 1'b0, addr: 32'h8000_0020, sel: 4'b1111, wdata: 32'h0, rdata: 32'h1234_5678, waits: 0, hold: 3, exp_cpu: 32'h1234_5678};
        vecs[3] = '{we: 1'b0, addr: 32'h0000_0004, sel: 4'b0011, wdata: 32'h0, rdata: 32'hCAFE_F00D, waits: 1, hold: 0, exp_cpu: 32'hCAFE_F00D};
        vecs[4] = '{we: 1'b0, addr: 32'h0000_0008, sel: 4'b1100, wdata: 32'h0, rdata: 32'h0BAD_C0DE, waits: 1, hold: 0, exp_cpu: 32'h0BAD_C0DE};
        vecs[5] = '{we: 1'b1, addr: 32'hFFFF_FFFC, sel: 4'b1000, wdata: 32'hA5A5_0000, rdata: 32'h7777_7777, waits: 2, hold: 0, exp_cpu: 32'h0};

        rst = 1'b1; cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0;
        cpu_data_i = '0; stall_i = '0; flush_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = '0;
        next_cycle();
        cpu_ce_i = 1'b1;
        @(negedge clk);
        check("rst_cyc_stb_we", {61'b0, wb_cyc_o, wb_stb_o, wb_we_o}, 64'd0);
        check("rst_adr", {32'b0, wb_adr_o}, 64'd0);
        check("rst_sel_dat", {28'b0, wb_sel_o, wb_dat_o}, 64'd0);
        check("rst_stall", {63'b0, stall_req_o}, 64'd0);
        check("rst_cpu_data", {32'b0, cpu_data_o}, 64'd0);
        next_cycle();
        rst = 1'b0;
        cpu_ce_i = 1'b0;

        // Ack while idle must not produce data or a bus cycle.
        wb_ack_i = 1'b1; wb_dat_i = 32'h1357_9BDF;
        @(negedge clk);
        check("idle_ack_data", {32'b0, cpu_data_o}, 64'd0);
        check("idle_ack_stall", {63'b0, stall_req_o}, 64'd0);
        next_cycle();
        wb_ack_i = 1'b0;
        @(negedge clk);
        check("idle_ack_cyc", {63'b0, wb_cyc_o}, 64'd0);
        next_cycle();

        // Vector table, issued back to back.
        cyc_before = bus_cycles;
        for (int i = 0; i < 6; i++) run_txn(vecs[i]);
        @(negedge clk);
        check("post_idle_cyc", {63'b0, wb_cyc_o}, 64'd0);
        check("post_idle_data", {32'b0, cpu_data_o}, 64'd0);
        check("b2b_bus_cycles", {32'b0, bus_cycles - cyc_before}, 64'd6);
        next_cycle();

        // Flush while idle: no request accepted.
        cpu_ce_i = 1'b1; flush_i = 1'b1; cpu_addr_i = 32'h0000_0100;
        @(negedge clk);
        check("idle_flush_stall", {63'b0, stall_req_o}, 64'd0);
        next_cycle();
        cpu_ce_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        check("idle_flush_cyc", {63'b0, wb_cyc_o}, 64'd0);
        next_cycle();

        // Flush in BUSY coinciding with ack.
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0200; cpu_sel_i = 4'hF;
        next_cycle();
        cpu_ce_i = 1'b0;
        flush_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'hFEED_FACE;
        @(negedge clk);
        check("flush_busy_cyc", {63'b0, wb_cyc_o}, 64'd1);
        check("flush_stall", {63'b0, stall_req_o}, 64'd0);
        check("flush_cpu_data", {32'b0, cpu_data_o}, 64'd0);
        next_cycle();
        flush_i = 1'b0; wb_ack_i = 1'b0;
        @(negedge clk);
        check("flush_cyc_drop", {62'b0, wb_cyc_o, wb_stb_o}, 64'd0);
        check("flush_after_data", {32'b0, cpu_data_o}, 64'd0);
        next_cycle();

        // Reset in BUSY abandons the cycle.
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0300; cpu_sel_i = 4'h1;
        next_cycle();
        cpu_ce_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy_comb_stall", {63'b0, stall_req_o}, 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy_drop", {61'b0, wb_cyc_o, wb_stb_o, wb_we_o}, 64'd0);
        check("rst_busy_stall", {63'b0, stall_req_o}, 64'd0);
        next_cycle();
        tv = '{we: 1'b0, addr: 32'h8000_0400, sel: 4'b1111, wdata: 32'h0, rdata: 32'h2468_ACE0, waits: 1, hold: 0, exp_cpu: 32'h2468_ACE0};
        run_txn(tv);
        @(negedge clk);
        check("after_rst_idle", {63'b0, wb_cyc_o}, 64'd0);
        check("sb_drained", {32'b0, sb.size()}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

endmodule
